irq_pc_ctl: RTL and testbench
=============================

// Module: irq_pc_ctl
// PURPOSE
//   Interrupt/PC-control sequencer driving the pc_prectl / irq / zz_spc inputs of pc_gen.
//   Latches edge-triggered interrupt lines and masks them. Prioritises them and issues
//   PC_IRQ. Saves the restart PC in zz_spc and holds further interrupts until a return
//   (PC_RET) retires the handler. Also sequences PC_RST after reset.
// PARAMETERS
//   N_IRQ     4             number of interrupt lines (1..8)
//   VEC_BASE  32'h0000_0050 handler entry address (vector 0)
//   RST_HOLD  2             cycles pc_prectl stays PC_RST after rst_n deasserts (>=1)
// PORTS
//   clock      in   1      single clock, rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   pause      in   1      pipeline stall; the FSM and all outputs hold while high
//   irq_i      in   N_IRQ  raw interrupt lines, rising-edge sensitive
//   mask_we    in   1      write strobe for the mask register
//   mask_d     in   N_IRQ  new mask value (1 = enabled)
//   ds_i       in   1      instruction in EX is a branch delay slot (take is not allowed)
//   epc_i      in   32     PC of the instruction to restart after the handler
//   ret_i      in   1      decoded return-from-interrupt in EX (same cycle pc_gen uses PC_RET)
//   pc_prectl  out  4      `PC_IGN / `PC_KEP / `PC_IRQ / `PC_RST to pc_gen
//   irq_addr   out  32     handler address to pc_gen.irq
//   zz_spc     out  32     saved restart PC to pc_gen.zz_spc
//   irq_ack    out  N_IRQ  one-hot, one-cycle pulse of the taken line
//   in_isr     out  1      handler active
//   pend_o     out  N_IRQ  pending register (debug/status)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=RST, pc_prectl=`PC_RST, irq_addr=VEC_BASE, zz_spc=0,
//     irq_ack=0, in_isr=0, pend=0, mask=0, irq_q=0, hold counter=0.
//   States: RST -> IDLE -> TAKE -> ISR -> IDLE. Encodings are `IRQ_ST_* constants.
//   RST: pc_prectl=`PC_RST. The counter advances when pause=0. After RST_HOLD clocks, go to IDLE.
//   IDLE: pc_prectl=`PC_IGN. If |(pend&mask) && !ds_i && !pause, go to TAKE next cycle.
//     The decision uses the registered mask value before any same-cycle mask_we.
//   TAKE (exactly 1 cycle):
//     - pc_prectl=`PC_IRQ and irq_addr = selected vector.
//     - zz_spc<=epc_i. The sel bit of pend is cleared.
//     - irq_ack=onehot(sel) in this cycle only. in_isr<=1, then go to ISR.
//   ISR: pc_prectl=`PC_IGN. New edges still set pend but are not taken.
//     ret_i=1 -> in_isr<=0 and go to IDLE. zz_spc holds until the next TAKE.
//   ret_i outside ISR is ignored.
//   Edge capture: irq_q<=irq_i every cycle, including during pause.
//     pend[k] <= (pend[k] & ~clr[k]) | (irq_i[k] & ~irq_q[k]). If set and clear occur together, set wins.
//   Priority: lowest index wins. sel is 0..N_IRQ-1.
//   pause=1 in TAKE: outputs hold, and irq_ack stays low until the cycle pause drops.
//     The ack pulse is issued once, in the first unpaused TAKE cycle.
//   mask_we applies at the clock edge regardless of state or pause.
//   Latency: irq_i edge at cycle n -> pend set at n+1 -> TAKE at n+2 (ds_i=0, pause=0).
//   Reset mid-ISR or mid-TAKE: immediate return to RST, and all state is cleared.
// CONFIGURATION
//   IRQ_VECTOR_EN defined: irq_addr = VEC_BASE + (sel << 3).
//     This gives 8-byte spacing per line.
//   IRQ_VECTOR_EN undefined: irq_addr = VEC_BASE for every line.
//     Software reads pend_o to find the source. sel still picks which bit is cleared and acked.
// STRUCTURE
//   The shared package mips789_defs.v provides:
//     - existing `PC_IGN/`PC_KEP/`PC_IRQ/`PC_RST and `__TP;
//     - new `IRQ_ST_RST/IDLE/TAKE/ISR (2-bit).
//   One sub-module: irq_prio_enc. It is combinational and maps a req vector to sel and any_req.
//   The FSM, pend/mask/irq_q registers and zz_spc stay in irq_pc_ctl.
// TESTING
//   Reset: release rst_n. Expect pc_prectl=`PC_RST for 2 cycles, then `PC_IGN.
//     zz_spc=0 and pend_o=0 throughout.
//   Basic take: mask=4'b0010, epc_i=32'h100, pulse irq_i[1].
//     Expect TAKE 2 cycles later: pc_prectl=`PC_IRQ, irq_ack=4'b0010, zz_spc=32'h100.
//     irq_addr=32'h58 with IRQ_VECTOR_EN, 32'h50 without.
//   Priority and nesting:
//     - irq_i[3] and irq_i[2] rise together with mask=4'hF. Line 2 is taken; pend_o=4'b1000.
//     - Line 3 is not taken until ret_i, then it is taken next.
//   Blocking conditions:
//     - Edge arrives with ds_i=1 held 3 cycles: no TAKE until ds_i drops.
//     - Edge arrives with mask bit 0: it stays pending. Setting the mask bit causes a TAKE.
//   Pause and reset:
//     - pause=1 across TAKE: pc_prectl holds `PC_IRQ and a single ack pulse is issued.
//     - rst_n low during ISR: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/irq_pc_ctl_pkg.sv
// Shared constants for the interrupt/PC-control sequencer: pc_gen control codes,
// sequencer state encoding and a width helper for the line-select index.
package irq_pc_ctl_pkg;

   localparam logic [3:0] PC_IGN = 4'd0;
   localparam logic [3:0] PC_KEP = 4'd1;
   localparam logic [3:0] PC_IRQ = 4'd2;
   localparam logic [3:0] PC_RST = 4'd3;

   typedef enum logic [1:0] {
      IRQ_ST_RST  = 2'd0,
      IRQ_ST_IDLE = 2'd1,
      IRQ_ST_TAKE = 2'd2,
      IRQ_ST_ISR  = 2'd3
   } irq_st_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_pc_ctl_if.sv
// Bundle of pipeline-side signals between the core and irq_pc_ctl.
// master drives the core-side inputs; slave is the sequencer view.
interface irq_pc_ctl_if #(parameter int N_IRQ = 4);

   logic             pause;
   logic [N_IRQ-1:0] irq_i;
   logic             mask_we;
   logic [N_IRQ-1:0] mask_d;
   logic             ds_i;
   logic [31:0]      epc_i;
   logic             ret_i;
   logic [3:0]       pc_prectl;
   logic [31:0]      irq_addr;
   logic [31:0]      zz_spc;
   logic [N_IRQ-1:0] irq_ack;
   logic             in_isr;
   logic [N_IRQ-1:0] pend_o;

   modport master (
      output pause, irq_i, mask_we, mask_d, ds_i, epc_i, ret_i,
      input  pc_prectl, irq_addr, zz_spc, irq_ack, in_isr, pend_o
   );

   modport slave (
      input  pause, irq_i, mask_we, mask_d, ds_i, epc_i, ret_i,
      output pc_prectl, irq_addr, zz_spc, irq_ack, in_isr, pend_o
   );

endinterface

// File: rtl/irq_pc_ctl_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest set index wins.
module irq_prio_enc
   import irq_pc_ctl_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = sel_width(N)
) (
   input  logic [N-1:0]  i_req,
   output logic [SW-1:0] o_sel,
   output logic          o_any
);

   always_comb begin
      o_sel = '0;
      o_any = |i_req;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[k]) o_sel = SW'(k);
      end
   end

endmodule

// File: rtl/irq_pc_ctl.sv
// Interrupt/PC-control sequencer for pc_gen: edge capture, masking, priority take,
// restart-PC save and post-reset PC_RST hold. IRQ_VECTOR_EN selects per-line vectors.
//
// state       | meaning
// IRQ_ST_RST  | holding pc_gen in PC_RST for RST_HOLD unpaused clocks
// IRQ_ST_IDLE | normal flow, waiting for an enabled pending line
// IRQ_ST_TAKE | redirecting to the handler, ack pulse on first unpaused cycle
// IRQ_ST_ISR  | handler running, new edges only pend until ret_i
module irq_pc_ctl
   import irq_pc_ctl_pkg::*;
#(
   parameter int          N_IRQ    = 4,
   parameter logic [31:0] VEC_BASE = 32'h0000_0050,
   parameter int          RST_HOLD = 2
) (
   input logic         clock,
   input logic         rst_n,
   irq_pc_ctl_if.slave bus
);

   localparam int             SW       = sel_width(N_IRQ);
   localparam int             CW       = $clog2(RST_HOLD + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(RST_HOLD - 1);

   irq_st_e          r_state;
   irq_st_e          w_next;
   logic [CW-1:0]    r_cnt;
   logic [N_IRQ-1:0] r_irq_q;
   logic [N_IRQ-1:0] r_pend;
   logic [N_IRQ-1:0] r_mask;
   logic [SW-1:0]    r_sel;
   logic [31:0]      r_irq_addr;
   logic [31:0]      r_zz_spc;
   logic             r_in_isr;

   logic [N_IRQ-1:0] w_req;
   logic [N_IRQ-1:0] w_edge;
   logic [N_IRQ-1:0] w_sel_oh;
   logic [N_IRQ-1:0] w_ack;
   logic [SW-1:0]    w_sel;
   logic             w_any;
   logic [31:0]      w_vec;
   logic [3:0]       w_pc;
   logic             w_cnt_step;
   logic             w_take_go;
   logic             w_take_done;
   logic             w_ret_done;

   assign w_req    = r_pend & r_mask;
   assign w_edge   = bus.irq_i & ~r_irq_q;
   assign w_sel_oh = N_IRQ'(1) << r_sel;

   irq_prio_enc #(.N(N_IRQ)) u_prio (
      .i_req (w_req),
      .o_sel (w_sel),
      .o_any (w_any)
   );

`ifdef IRQ_VECTOR_EN
   assign w_vec = VEC_BASE + (32'(w_sel) << 3);
`else
   assign w_vec = VEC_BASE;
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) r_state <= IRQ_ST_RST;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_pc        = PC_IGN;
      w_ack       = '0;
      w_cnt_step  = 1'b0;
      w_take_go   = 1'b0;
      w_take_done = 1'b0;
      w_ret_done  = 1'b0;
      case (r_state)
         IRQ_ST_RST: begin
            w_pc = PC_RST;
            if (!bus.pause) begin
               if (r_cnt == CNT_LAST) w_next = IRQ_ST_IDLE;
               else                   w_cnt_step = 1'b1;
            end
         end
         IRQ_ST_IDLE: begin
            if (w_any && !bus.ds_i && !bus.pause) begin
               w_next    = IRQ_ST_TAKE;
               w_take_go = 1'b1;
            end
         end
         IRQ_ST_TAKE: begin
            w_pc = PC_IRQ;
            // the ack and pend clear wait for the cycle the pipeline actually moves
            if (!bus.pause) begin
               w_ack       = w_sel_oh;
               w_take_done = 1'b1;
               w_next      = IRQ_ST_ISR;
            end
         end
         IRQ_ST_ISR: begin
            if (bus.ret_i && !bus.pause) begin
               w_ret_done = 1'b1;
               w_next     = IRQ_ST_IDLE;
            end
         end
         default: w_next = IRQ_ST_RST;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_irq_q    <= '0;
         r_pend     <= '0;
         r_mask     <= '0;
         r_sel      <= '0;
         r_irq_addr <= VEC_BASE;
         r_zz_spc   <= '0;
         r_in_isr   <= 1'b0;
      end else begin
         r_irq_q <= bus.irq_i;
         r_pend  <= (r_pend & ~w_ack) | w_edge;
         if (bus.mask_we)  r_mask <= bus.mask_d;
         if (w_cnt_step)   r_cnt  <= r_cnt + CW'(1);
         if (w_take_go) begin
            r_sel      <= w_sel;
            r_irq_addr <= w_vec;
         end
         // loaded on entry so TAKE already shows it, refreshed when TAKE retires
         if (w_take_go || w_take_done) r_zz_spc <= bus.epc_i;
         if (w_take_done)     r_in_isr <= 1'b1;
         else if (w_ret_done) r_in_isr <= 1'b0;
      end
   end

   assign bus.pc_prectl = w_pc;
   assign bus.irq_addr  = r_irq_addr;
   assign bus.zz_spc    = r_zz_spc;
   assign bus.irq_ack   = w_ack;
   assign bus.in_isr    = r_in_isr;
   assign bus.pend_o    = r_pend;

endmodule

// File: tb/tb_irq_pc_ctl.sv
// Bench for irq_pc_ctl: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the sequencer.
module tb_irq_pc_ctl;
   import irq_pc_ctl_pkg::*;

   localparam int          N  = 4;
   localparam logic [31:0] VB = 32'h0000_0050;
   localparam int          RH = 2;
`ifdef IRQ_VECTOR_EN
   localparam bit VEC_EN = 1'b1;
`else
   localparam bit VEC_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic rst_n;
   always #5 clock = ~clock;

   irq_pc_ctl_if #(.N_IRQ(N)) bus ();

   irq_pc_ctl #(.N_IRQ(N), .VEC_BASE(VB), .RST_HOLD(RH)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // model: remaining PC_RST cycles, take/handler flags, pending bits as plain vectors
   int          m_rst_left;
   bit          m_taking;
   bit          m_handler;
   bit [N-1:0]  m_pend;
   bit [N-1:0]  m_mask;
   bit [N-1:0]  m_prev;
   int          m_sel;
   logic [31:0] m_addr;
   logic [31:0] m_spc;

   function automatic void model_reset();
      m_rst_left = RH;
      m_taking   = 1'b0;
      m_handler  = 1'b0;
      m_pend     = '0;
      m_mask     = '0;
      m_prev     = '0;
      m_sel      = 0;
      m_addr     = VB;
      m_spc      = '0;
   endfunction

   function automatic void model_step();
      bit [N-1:0] rise;
      bit [N-1:0] clr;
      bit [N-1:0] ready;
      bit         found;
      rise  = bus.irq_i & ~m_prev;
      clr   = '0;
      ready = m_pend & m_mask;
      if (m_rst_left > 0) begin
         if (!bus.pause) m_rst_left--;
      end else if (m_taking) begin
         if (!bus.pause) begin
            clr[m_sel] = 1'b1;
            m_spc      = bus.epc_i;
            m_taking   = 1'b0;
            m_handler  = 1'b1;
         end
      end else if (m_handler) begin
         if (bus.ret_i && !bus.pause) m_handler = 1'b0;
      end else if (ready != 0 && !bus.ds_i && !bus.pause) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (ready[k] && !found) begin
               m_sel = k;
               found = 1'b1;
            end
         end
         m_taking = 1'b1;
         m_addr   = VB + (VEC_EN ? 32'(m_sel * 8) : 32'd0);
         m_spc    = bus.epc_i;
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = bus.irq_i;
      if (bus.mask_we) m_mask = bus.mask_d;
   endfunction

   task automatic check_outputs(input string ph);
      logic [3:0]   e_pc;
      logic [N-1:0] e_ack;
      e_pc  = (m_rst_left > 0) ? PC_RST : (m_taking ? PC_IRQ : PC_IGN);
      e_ack = (m_taking && !bus.pause) ? N'(1 << m_sel) : '0;
      check_val({ph, ".pc_prectl"}, 32'(bus.pc_prectl), 32'(e_pc));
      check_val({ph, ".irq_addr"},  bus.irq_addr, m_addr);
      check_val({ph, ".zz_spc"},    bus.zz_spc, m_spc);
      check_val({ph, ".irq_ack"},   32'(bus.irq_ack), 32'(e_ack));
      check_val({ph, ".in_isr"},    32'(bus.in_isr), 32'(m_handler));
      check_val({ph, ".pend_o"},    32'(bus.pend_o), 32'(m_pend));
   endtask

   // called at a falling edge with inputs already applied
   task automatic cycle();
      #1;
      check_outputs("cyc");
      if (rst_n) model_step();
      @(negedge clock);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic quiet();
      bus.pause   = 1'b0;
      bus.irq_i   = '0;
      bus.mask_we = 1'b0;
      bus.mask_d  = '0;
      bus.ds_i    = 1'b0;
      bus.ret_i   = 1'b0;
   endtask

   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("arst");
      check_val("arst.pc_rst", 32'(bus.pc_prectl), 32'(PC_RST));
      @(negedge clock);
      quiet();
      run(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      quiet();
      bus.epc_i = 32'h0000_0100;
      model_reset();
      repeat (2) @(negedge clock);
      check_outputs("rst");
      rst_n = 1'b1;
      run(4);

      // basic take on line 1
      bus.mask_we = 1'b1; bus.mask_d = 4'b0010; run(1);
      bus.mask_we = 1'b0; bus.irq_i = 4'b0010;  run(1);
      bus.irq_i = '0; run(1);
      check_val("basic.pc",   32'(bus.pc_prectl), 32'(PC_IRQ));
      check_val("basic.ack",  32'(bus.irq_ack), 32'h2);
      check_val("basic.zz",   bus.zz_spc, 32'h100);
      check_val("basic.addr", bus.irq_addr, VEC_EN ? 32'h58 : 32'h50);
      run(3);
      bus.ret_i = 1'b1; run(1); bus.ret_i = 1'b0; run(2);

      // simultaneous 3 and 2, 2 first, 3 after return
      bus.mask_we = 1'b1; bus.mask_d = 4'hF; run(1);
      bus.mask_we = 1'b0; bus.irq_i = 4'b1100; run(1);
      bus.irq_i = '0; run(1);
      check_val("prio.ack2", 32'(bus.irq_ack), 32'h4);
      run(1);
      check_val("prio.pend3", 32'(bus.pend_o), 32'h8);
      run(3);
      check_val("prio.nest_blocked", 32'(bus.pc_prectl), 32'(PC_IGN));
      bus.ret_i = 1'b1; run(1); bus.ret_i = 1'b0; run(1);
      check_val("prio.ack3", 32'(bus.irq_ack), 32'h8);
      run(2);
      bus.ret_i = 1'b1; run(1); bus.ret_i = 1'b0; run(1);

      // delay slot blocks the take
      bus.ds_i = 1'b1; bus.irq_i = 4'b0001; run(1);
      bus.irq_i = '0; run(3);
      check_val("ds.blocked", 32'(bus.pc_prectl), 32'(PC_IGN));
      bus.ds_i = 1'b0; run(1);
      check_val("ds.take", 32'(bus.pc_prectl), 32'(PC_IRQ));
      run(2); bus.ret_i = 1'b1; run(1); bus.ret_i = 1'b0; run(1);

      // masked line stays pending until enabled
      bus.mask_we = 1'b1; bus.mask_d = 4'b1110; run(1);
      bus.mask_we = 1'b0; bus.irq_i = 4'b0001; run(1);
      bus.irq_i = '0; run(3);
      check_val("mask.pending", 32'(bus.pend_o), 32'h1);
      bus.mask_we = 1'b1; bus.mask_d = 4'hF; run(1);
      bus.mask_we = 1'b0; run(1);
      check_val("mask.take", 32'(bus.pc_prectl), 32'(PC_IRQ));
      run(2); bus.ret_i = 1'b1; run(1); bus.ret_i = 1'b0; run(1);

      // pause across TAKE, then reset inside the handler
      bus.epc_i = 32'h0000_0abc;
      bus.irq_i = 4'b0010; run(1);
      bus.irq_i = '0; run(1);
      bus.pause = 1'b1; run(3);
      check_val("pause.hold_pc", 32'(bus.pc_prectl), 32'(PC_IRQ));
      bus.pause = 1'b0; run(3);
      check_val("pause.in_isr", 32'(bus.in_isr), 32'h1);
      do_reset();
      run(4);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(299) == 0) begin
            do_reset();
         end else begin
            for (int k = 0; k < N; k++)
               if ($urandom_range(3) == 0) bus.irq_i[k] = ~bus.irq_i[k];
            bus.pause   = ($urandom_range(9) == 0);
            bus.ds_i    = ($urandom_range(6) == 0);
            bus.ret_i   = ($urandom_range(3) == 0);
            bus.mask_we = ($urandom_range(19) == 0);
            bus.mask_d  = N'($urandom);
            bus.epc_i   = $urandom;
            cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
